// File: rtl/sal_ddr2_pkg.sv
// Shared DDR2 controller definitions: refresh sequencer states and widths.
package sal_ddr2_pkg;

    localparam int DEBT_W         = 4;
    localparam int REF_URG_TH_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_PREA     = 3'd2,
        ST_WAIT_RP  = 3'd3,
        ST_REF      = 3'd4,
        ST_WAIT_RFC = 3'd5
    } ref_state_t;

    // Down-counter preload so that a delay of 0 behaves like a delay of 1.
    function automatic logic [7:0] dly_load(input logic [7:0] cycles);
        return (cycles == 8'd0) ? 8'd0 : cycles - 8'd1;
    endfunction

endpackage

// File: rtl/sal_ref_timer.sv
// tREFI interval timer: emits a one-cycle tick every cfg_trefi_i enabled cycles.
module sal_ref_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        ref_en_i,
    input  logic [15:0] cfg_trefi_i,
    output logic        tick_o
);

    logic [15:0] tmr_q;
    logic [15:0] tmr_d;
    logic        cfg_ok;
    logic        at_end;

    assign cfg_ok = (cfg_trefi_i >= 16'd2);
    assign at_end = (tmr_q >= cfg_trefi_i - 16'd1);
    assign tick_o = ref_en_i && cfg_ok && (tmr_q == cfg_trefi_i - 16'd1);

    always_comb begin
        tmr_d = tmr_q + 16'd1;
        if (!ref_en_i || !cfg_ok || at_end) begin
            tmr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

endmodule

// File: rtl/sal_ref_ctrl.sv
// All-bank auto-refresh sequencer: accrues refresh debt, drains and closes banks,
// then issues REFRESH commands while enforcing tRP / tRFC.
module sal_ref_ctrl
    import sal_ddr2_pkg::*;
#(
    parameter int BK_CNT   = 8,
    parameter int DEBT_MAX = 8,
    parameter int URG_TH   = REF_URG_TH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ref_en_i,
    input  logic [15:0]       cfg_trefi_i,
    input  logic [3:0]        cfg_trp_i,
    input  logic [7:0]        cfg_trfc_i,
    input  logic [BK_CNT-1:0] bk_idle_i,
    input  logic [BK_CNT-1:0] bk_open_i,
    output logic              block_o,
    output logic              prea_req_o,
    input  logic              prea_gnt_i,
    output logic              ref_req_o,
    input  logic              ref_gnt_i,
    output logic [DEBT_W-1:0] debt_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [DEBT_W-1:0] DEBT_MAX_C = DEBT_W'(DEBT_MAX);
    localparam logic [DEBT_W-1:0] URG_TH_C   = DEBT_W'(URG_TH);

    ref_state_t        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DEBT_W-1:0] debt_q, debt_d;
    logic              err_q, err_d;
    logic              tick;
    logic              ref_grant;
    logic              banks_idle;
    logic              banks_open;
    logic              debt_urgent;

    sal_ref_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .ref_en_i    (ref_en_i),
        .cfg_trefi_i (cfg_trefi_i),
        .tick_o      (tick)
    );

    assign banks_idle  = &bk_idle_i;
    assign banks_open  = |bk_open_i;
    assign debt_urgent = (debt_q >= URG_TH_C);
    // Grants outside the REF state are ignored.
    assign ref_grant   = (state_q == ST_REF) && ref_gnt_i;

    always_comb begin
        debt_d = debt_q;
        err_d  = err_q;
        if (tick && !ref_grant) begin
            if (debt_q >= DEBT_MAX_C) begin
                err_d = 1'b1;
            end else begin
                debt_d = debt_q + 1'b1;
            end
        end else if (ref_grant && !tick && (debt_q != '0)) begin
            debt_d = debt_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ref_en_i && (debt_urgent || ((debt_q != '0) && banks_idle))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (banks_idle) begin
                    state_d = banks_open ? ST_PREA : ST_REF;
                end
            end
            ST_PREA: begin
                if (prea_gnt_i) begin
                    cnt_d   = dly_load({4'd0, cfg_trp_i});
                    state_d = ST_WAIT_RP;
                end
            end
            ST_WAIT_RP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_REF;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_REF: begin
                if (ref_gnt_i) begin
                    cnt_d   = dly_load(cfg_trfc_i);
                    state_d = ST_WAIT_RFC;
                end
            end
            ST_WAIT_RFC: begin
                // Banks are still closed, so an urgent backlog skips straight to REF.
                if (cnt_q == 8'd0) begin
                    state_d = debt_urgent ? ST_REF : ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            debt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            debt_q  <= debt_d;
            err_q   <= err_d;
        end
    end

    assign block_o    = (state_q != ST_IDLE);
    assign busy_o     = (state_q != ST_IDLE);
    assign prea_req_o = (state_q == ST_PREA);
    assign ref_req_o  = (state_q == ST_REF);
    assign debt_o     = debt_q;
    assign err_o      = err_q;

endmodule
